line_fetch_unit: RTL and testbench
==================================

LINE_FETCH_UNIT -- requirements
Module: line_fetch_unit

Interface
REQ-001 Parameter ADDR_W, default 32, address width in words.
REQ-002 Parameter WORD_W, default 32, instruction word width.
REQ-003 Parameter LINE_WORDS, default 4, words per cache line; only value 4 is supported.
REQ-004 clk  input  1  single clock; all state updates on its rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 miss_req  input  1  cache requests a line refill; level, sampled in IDLE only.
REQ-007 miss_addr  input  ADDR_W  word address of the missing instruction.
REQ-008 busy  output  1  high whenever state is not IDLE.
REQ-009 line_valid  output  1  one-cycle pulse: data_line and line_base are complete.
REQ-010 data_line  output  128  assembled line; word offset 0 at [127:96], offset 3 at [31:0].
REQ-011 line_base  output  ADDR_W  line-aligned address of data_line, {addr[ADDR_W-1:2],2'b00}.
REQ-012 mem_req  output  1  word read request to main memory.
REQ-013 mem_addr  output  ADDR_W  word address being read.
REQ-014 mem_rdata  input  WORD_W  memory read data, valid when mem_ready is high.
REQ-015 mem_ready  input  1  memory completes the current word read this cycle.

Function
REQ-016 FSM states: IDLE, FETCH, DONE.
REQ-017 IDLE: if miss_req=1, latch base={miss_addr[ADDR_W-1:2],2'b00}, clear word counter k, go to FETCH next cycle.
REQ-018 FETCH: mem_req=1, mem_addr=base+k (k is 2 bits, no carry into upper address bits).
REQ-019 FETCH with mem_ready=1: write mem_rdata into the slot for offset k; increment k.
REQ-020 FETCH with mem_ready=1 and k=3: go to DONE; mem_req deasserts in the DONE cycle.
REQ-021 FETCH with mem_ready=0: hold k, mem_addr and mem_req stable; no timeout.
REQ-022 DONE: line_valid=1 for exactly one cycle; line_base=base; return to IDLE.
REQ-023 data_line and line_base hold their values from DONE until the next request is accepted in IDLE.
REQ-024 miss_req while busy=1, including in the DONE cycle, is ignored; the cache re-raises it.
REQ-025 The refill latency is 1 accept cycle plus the 4 FETCH cycles that have mem_ready=1, plus stall cycles, plus 1 DONE cycle; the minimum is 6 cycles from miss_req to the line_valid pulse.
REQ-026 mem_ready outside FETCH is ignored.
REQ-027 miss_addr changing after acceptance has no effect.

Reset
REQ-028 When reset=1 at a clock edge: state goes to IDLE, k=0, busy=0, line_valid=0, mem_req=0, mem_addr=0, data_line=0, line_base=0.
REQ-029 Reset during FETCH discards the partial line; mem_req drops at that same edge.
REQ-030 Reset has priority over miss_req and mem_ready in the same cycle.

Structure
REQ-031 The shared package holds the FSM state enum, LINE_WORDS, and the offset-to-slot mapping (slot k occupies bits [127-32k : 96-32k]).
REQ-032 The design has one sub-module, line_buf: a 128-bit register with per-word write enable and synchronous clear.

Verification
REQ-033 Test 1: miss_addr=0x0000_0105, mem_ready=1 constantly, and mem_rdata=addr+0xA000. Required response: mem_addr sequence is 0x104..0x107; line_valid pulses at cycle 6; data_line={A104,A105,A106,A107}; line_base=0x104.
REQ-034 Test 2: mem_ready low for 3 cycles on word 2. Required response: mem_addr holds 0x106 for 4 cycles; line_valid is delayed by 3 cycles; data_line is correct.
REQ-035 Test 3: reset asserted during word 1 of a fetch. Required response: at the next edge busy=0, mem_req=0, data_line=0; no line_valid pulse occurs.
REQ-036 Test 4: miss_req held high through DONE. Required response: exactly one line_valid pulse occurs, and a new fetch starts the cycle after DONE.
REQ-037 Test 5: miss_addr=0xFFFF_FFFF. Required response: mem_addr sequence is 0xFFFF_FFFC..0xFFFF_FFFF with no wrap past the line.
REQ-038 Test 6: back-to-back misses to 0x200 then 0x310. Required response: data_line and line_base update only on each DONE, and the values are stable between the two fetches.

Source files
------------

// File: rtl/line_fetch_unit_pkg.sv
// Shared definitions for the instruction line fetch unit.
package line_fetch_unit_pkg;

  // Words per cache line; the slot mapping below assumes exactly four.
  localparam int unsigned NumLineWords = 4;

  typedef enum logic [1:0] {
    StIdle,
    StFetch,
    StDone
  } lfu_state_e;

  // Word offset k lives at bits [127-32k : 96-32k]: offset 0 is the most significant word.
  function automatic int unsigned slot_lsb(input logic [1:0] k, input int unsigned word_w);
    return (NumLineWords - 1 - 32'(k)) * word_w;
  endfunction

endpackage

// File: rtl/line_fetch_unit_line_buf.sv
// Line assembly buffer: one register per word slot, per-word write enable, synchronous clear.
module line_buf
  import line_fetch_unit_pkg::*;
#(
  parameter int unsigned WORD_W     = 32,
  parameter int unsigned LINE_WORDS = 4
) (
  input  logic                         clk_i,
  input  logic                         reset_i,
  input  logic                         clr_i,
  input  logic [LINE_WORDS-1:0]        wr_en_i,
  input  logic [WORD_W-1:0]            wr_data_i,
  output logic [LINE_WORDS*WORD_W-1:0] line_o
);

  logic [LINE_WORDS*WORD_W-1:0] line_q;

  // Clear on reset or on a new request; otherwise write the enabled word slot.
  always_ff @(posedge clk_i) begin
    if (reset_i || clr_i) begin
      line_q <= '0;
    end else begin
      for (int i = 0; i < LINE_WORDS; i++) begin
        if (wr_en_i[i]) begin
          line_q[slot_lsb(2'(i), WORD_W) +: WORD_W] <= wr_data_i;
        end
      end
    end
  end

  assign line_o = line_q;

endmodule

// File: rtl/line_fetch_unit.sv
// Refills one 4-word instruction cache line from word-wide main memory on a miss.
module line_fetch_unit
  import line_fetch_unit_pkg::*;
#(
  parameter int unsigned ADDR_W     = 32,
  parameter int unsigned WORD_W     = 32,
  parameter int unsigned LINE_WORDS = 4
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         miss_req,
  input  logic [ADDR_W-1:0]            miss_addr,
  output logic                         busy,
  output logic                         line_valid,
  output logic [LINE_WORDS*WORD_W-1:0] data_line,
  output logic [ADDR_W-1:0]            line_base,
  output logic                         mem_req,
  output logic [ADDR_W-1:0]            mem_addr,
  input  logic [WORD_W-1:0]            mem_rdata,
  input  logic                         mem_ready
);

  lfu_state_e                   state_q;
  logic [1:0]                   k_q;
  logic [ADDR_W-1:0]            base_q;
  logic                         busy_q;
  logic                         line_valid_q;
  logic                         mem_req_q;
  logic [ADDR_W-1:0]            mem_addr_q;
  logic [LINE_WORDS*WORD_W-1:0] data_line_q;
  logic [ADDR_W-1:0]            line_base_q;

  logic                         buf_clr;
  logic [LINE_WORDS-1:0]        buf_wr_en;
  logic [LINE_WORDS*WORD_W-1:0] buf_line;
  logic [LINE_WORDS*WORD_W-1:0] line_merged;

  // Offset bits of the miss address are dropped by line alignment.
  logic unused_miss_addr_lo;
  assign unused_miss_addr_lo = ^miss_addr[1:0];

  // Buffer control: clear when a request is accepted, write the current slot on each beat.
  always_comb begin
    buf_clr   = (state_q == StIdle) && miss_req;
    buf_wr_en = '0;
    if ((state_q == StFetch) && mem_ready) begin
      buf_wr_en[k_q] = 1'b1;
    end
  end

  // Complete line including the word arriving this cycle, so the output can load at the last beat.
  always_comb begin
    line_merged = buf_line;
    line_merged[slot_lsb(k_q, WORD_W) +: WORD_W] = mem_rdata;
  end

  line_buf #(
    .WORD_W    (WORD_W),
    .LINE_WORDS(LINE_WORDS)
  ) u_line_buf (
    .clk_i    (clk),
    .reset_i  (reset),
    .clr_i    (buf_clr),
    .wr_en_i  (buf_wr_en),
    .wr_data_i(mem_rdata),
    .line_o   (buf_line)
  );

  // Control FSM with registered outputs; the visible line only changes on entry to DONE.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= StIdle;
      k_q          <= '0;
      base_q       <= '0;
      busy_q       <= 1'b0;
      line_valid_q <= 1'b0;
      mem_req_q    <= 1'b0;
      mem_addr_q   <= '0;
      data_line_q  <= '0;
      line_base_q  <= '0;
    end else begin
      line_valid_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (miss_req) begin
            state_q    <= StFetch;
            base_q     <= {miss_addr[ADDR_W-1:2], 2'b00};
            k_q        <= '0;
            busy_q     <= 1'b1;
            mem_req_q  <= 1'b1;
            mem_addr_q <= {miss_addr[ADDR_W-1:2], 2'b00};
          end
        end
        StFetch: begin
          if (mem_ready) begin
            k_q        <= k_q + 2'd1;
            mem_addr_q <= {base_q[ADDR_W-1:2], k_q + 2'd1};
            if (k_q == 2'd3) begin
              state_q      <= StDone;
              mem_req_q    <= 1'b0;
              line_valid_q <= 1'b1;
              data_line_q  <= line_merged;
              line_base_q  <= base_q;
            end
          end
        end
        StDone: begin
          state_q <= StIdle;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= StIdle;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign busy       = busy_q;
  assign line_valid = line_valid_q;
  assign mem_req    = mem_req_q;
  assign mem_addr   = mem_addr_q;
  assign data_line  = data_line_q;
  assign line_base  = line_base_q;

endmodule

// File: tb/tb_line_fetch_unit.sv
// Bench for line_fetch_unit: directed scenarios with literal expectations plus randomized traffic,
// all checked every cycle against a transaction-level reference model.
module tb_line_fetch_unit;

  logic         clk = 1'b0;
  logic         reset;
  logic         miss_req;
  logic [31:0]  miss_addr;
  logic         busy;
  logic         line_valid;
  logic [127:0] data_line;
  logic [31:0]  line_base;
  logic         mem_req;
  logic [31:0]  mem_addr;
  logic [31:0]  mem_rdata;
  logic         mem_ready;

  int checks = 0;
  int errors = 0;
  bit data_mode = 1'b0;

  always #5 clk = ~clk;

  line_fetch_unit #(
    .ADDR_W    (32),
    .WORD_W    (32),
    .LINE_WORDS(4)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .miss_req  (miss_req),
    .miss_addr (miss_addr),
    .busy      (busy),
    .line_valid(line_valid),
    .data_line (data_line),
    .line_base (line_base),
    .mem_req   (mem_req),
    .mem_addr  (mem_addr),
    .mem_rdata (mem_rdata),
    .mem_ready (mem_ready)
  );

  // Memory contents as a pure function of the word address.
  function automatic logic [31:0] data_fn(input logic [31:0] a, input bit mode);
    if (mode) return (a * 32'h9E37_79B1) ^ 32'h5A5A_0000;
    return a + 32'h0000_A000;
  endfunction

  assign mem_rdata = data_fn(mem_addr, data_mode);

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Refill as a transaction: idle -> collect four words (one per ready beat) -> one publish cycle.
  int           m_phase = 0;          // 0 idle, 1 collecting, 2 publishing
  int           m_got = 0;            // words collected so far
  logic [31:0]  m_base = '0;
  logic [31:0]  m_words[4];
  bit           m_valid = 1'b0;
  logic [127:0] m_line = '0;
  logic [31:0]  m_lbase = '0;
  bit           m_after_reset = 1'b0;
  bit           m_started = 1'b0;

  always @(posedge clk) begin
    m_started = 1'b1;
    if (reset) begin
      m_phase = 0; m_got = 0; m_base = '0; m_valid = 1'b0;
      m_line = '0; m_lbase = '0; m_after_reset = 1'b1;
    end else begin
      m_after_reset = 1'b0;
      m_valid = 1'b0;
      if (m_phase == 2) begin
        m_phase = 0;
      end else if (m_phase == 1) begin
        if (mem_ready) begin
          m_words[m_got] = mem_rdata;
          m_got++;
          if (m_got == 4) begin
            m_phase = 2;
            m_valid = 1'b1;
            m_line  = {m_words[0], m_words[1], m_words[2], m_words[3]};
            m_lbase = m_base;
          end
        end
      end else if (miss_req) begin
        m_base  = miss_addr & ~32'd3;
        m_got   = 0;
        m_phase = 1;
      end
    end
  end

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (m_started) begin
      chk("busy", 128'(busy), 128'(m_phase != 0));
      chk("line_valid", 128'(line_valid), 128'(m_valid));
      chk("mem_req", 128'(mem_req), 128'(m_phase == 1));
      chk("data_line", data_line, m_line);
      chk("line_base", 128'(line_base), 128'(m_lbase));
      if (m_phase == 1) chk("mem_addr", 128'(mem_addr), 128'(m_base + 32'(m_got)));
      else if (m_after_reset) chk("mem_addr_rst", 128'(mem_addr), 128'd0);
    end
  end

  // ---------------- directed helpers ----------------
  logic [31:0]  addr_q[$];
  bit           req_hist[0:31];
  logic [127:0] mid_line;

  task automatic idle(input int n);
    miss_req = 1'b0;
    for (int i = 0; i < n; i++) begin
      @(posedge clk); @(negedge clk);
    end
  endtask

  // One refill with memory stalling `sl` beats on word `sw`; edges counted from the accept edge.
  task automatic run_fetch(input logic [31:0] a, input int sw, input int sl, input bit hold_req,
                           output int lv_edge, output int n_lv, output int addr_hold);
    lv_edge = -1; n_lv = 0; addr_hold = 0;
    addr_q.delete();
    miss_addr = a;
    miss_req  = 1'b1;
    for (int e = 1; e <= 8 + sl; e++) begin
      mem_ready = !(e >= 2 + sw && e < 2 + sw + sl);
      @(posedge clk); @(negedge clk);
      if (!hold_req) begin
        miss_req  = 1'b0;
        miss_addr = $urandom;  // changes after acceptance must not matter
      end
      req_hist[e] = mem_req;
      if (line_valid) begin n_lv++; if (lv_edge < 0) lv_edge = e; end
      if (mem_req) begin
        addr_q.push_back(mem_addr);
        if (mem_addr == ((a & ~32'd3) | 32'd2)) addr_hold++;
      end
      if (e == 3) mid_line = data_line;
    end
    miss_req = 1'b0;
  endtask

  int lv_edge, n_lv, addr_hold, lv_cnt;

  initial begin
    reset = 1'b1; miss_req = 1'b0; miss_addr = '0; mem_ready = 1'b0;
    @(posedge clk); @(negedge clk);
    @(posedge clk); @(negedge clk);
    chk("reset_busy", 128'(busy), 128'd0);
    chk("reset_mem_addr", 128'(mem_addr), 128'd0);
    chk("reset_data_line", data_line, 128'd0);
    reset = 1'b0;
    idle(2);

    // Test 1: basic refill, mem_ready always high.
    run_fetch(32'h0000_0105, 0, 0, 1'b0, lv_edge, n_lv, addr_hold);
    chk("t1_addr_count", 128'(addr_q.size()), 128'd4);
    for (int i = 0; i < 4 && i < addr_q.size(); i++)
      chk("t1_addr_seq", 128'(addr_q[i]), 128'(32'h104 + 32'(i)));
    chk("t1_lv_edge", 128'(lv_edge), 128'd5);
    chk("t1_lv_count", 128'(n_lv), 128'd1);
    chk("t1_data_line", data_line, 128'h0000A104_0000A105_0000A106_0000A107);
    chk("t1_line_base", 128'(line_base), 128'h104);
    idle(2);

    // Test 2: three stall beats on word 2.
    run_fetch(32'h0000_0106, 2, 3, 1'b0, lv_edge, n_lv, addr_hold);
    chk("t2_addr_hold", 128'(addr_hold), 128'd4);
    chk("t2_lv_edge", 128'(lv_edge), 128'd8);
    chk("t2_data_line", data_line, 128'h0000A104_0000A105_0000A106_0000A107);
    idle(2);

    // Test 3: reset while word 1 is outstanding.
    miss_addr = 32'h0000_0300; miss_req = 1'b1; mem_ready = 1'b1;
    @(posedge clk); @(negedge clk); miss_req = 1'b0;
    @(posedge clk); @(negedge clk);
    reset = 1'b1;
    @(posedge clk); @(negedge clk);
    reset = 1'b0;
    chk("t3_busy", 128'(busy), 128'd0);
    chk("t3_mem_req", 128'(mem_req), 128'd0);
    chk("t3_data_line", data_line, 128'd0);
    lv_cnt = 0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); @(negedge clk);
      if (line_valid) lv_cnt++;
    end
    chk("t3_no_lv", 128'(lv_cnt), 128'd0);

    // Test 4: miss_req held through DONE.
    run_fetch(32'h0000_0040, 0, 0, 1'b1, lv_edge, n_lv, addr_hold);
    chk("t4_lv_count", 128'(n_lv), 128'd1);
    chk("t4_idle_after_done", 128'(req_hist[6]), 128'd0);
    chk("t4_refetch", 128'(req_hist[7]), 128'd1);
    idle(10);

    // Test 5: top-of-memory line, no wrap beyond the line.
    run_fetch(32'hFFFF_FFFF, 0, 0, 1'b0, lv_edge, n_lv, addr_hold);
    chk("t5_addr_count", 128'(addr_q.size()), 128'd4);
    for (int i = 0; i < 4 && i < addr_q.size(); i++)
      chk("t5_addr_seq", 128'(addr_q[i]), 128'(32'hFFFF_FFFC + 32'(i)));
    chk("t5_line_base", 128'(line_base), 128'hFFFF_FFFC);
    idle(2);

    // Test 6: back-to-back misses; output line only moves on DONE.
    run_fetch(32'h0000_0200, 0, 0, 1'b0, lv_edge, n_lv, addr_hold);
    chk("t6_line_a", data_line, 128'h0000A200_0000A201_0000A202_0000A203);
    chk("t6_base_a", 128'(line_base), 128'h200);
    run_fetch(32'h0000_0310, 0, 0, 1'b0, lv_edge, n_lv, addr_hold);
    chk("t6_mid_line", mid_line, 128'h0000A200_0000A201_0000A202_0000A203);
    chk("t6_line_b", data_line, 128'h0000A310_0000A311_0000A312_0000A313);
    chk("t6_base_b", 128'(line_base), 128'h310);
    idle(2);

    // Randomized traffic checked by the model.
    data_mode = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      reset     = ($urandom_range(0, 99) == 0);
      miss_req  = ($urandom_range(0, 1) == 1);
      miss_addr = $urandom;
      mem_ready = ($urandom_range(0, 9) < 7);
      @(posedge clk); @(negedge clk);
    end
    reset = 1'b0; miss_req = 1'b0;
    idle(4);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
